// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int unsigned id_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned count_w(input int unsigned fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    function automatic int unsigned burst_w(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above rr_ptr, wrapping to the lowest set bit.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    logic          hi_any;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Scan downward so the last hit in each class is the lowest index.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (IW'(i) >= rr_ptr) begin
                    hi_any = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
    end

    assign any = |req;
    assign idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned IW         = id_w(NUM_REQ),
    localparam int unsigned CW         = count_w(FIFO_DEPTH),
    localparam int unsigned BW         = burst_w(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic [CW-1:0]                 fifo_count,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_id,
    output logic [BW-1:0]                 burst_cnt
);

    localparam logic [CW-1:0] START_THRESH = CW'(FIFO_DEPTH - MAX_BURST);
    localparam logic [BW-1:0] LAST_BEAT    = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_ID      = IW'(NUM_REQ - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            can_start;
    logic            beat_acc;
    logic [DATA_WIDTH-1:0] req_beat [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_beat[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Next-state and write-port steering.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        beat_acc     = 1'b0;
        // Only start when a whole burst is guaranteed to fit.
        can_start    = pick_any && (fifo_count <= START_THRESH);

        case (state_q)
            IDLE: begin
                if (can_start) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                req_ready[grant_id_q] = !fifo_full;
                fifo_wr_data          = req_beat[grant_id_q];
                beat_acc              = req_valid[grant_id_q] && !fifo_full;
                fifo_wr_en            = beat_acc;
                if (beat_acc) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (req_last[grant_id_q] || (burst_cnt_q == LAST_BEAT)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grant_id_q;
    assign burst_cnt   = burst_cnt_q;

endmodule
